// File: rtl/shift_pkg.sv
// Shared types and encodings for the shift register controller.
package shift_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ROT = 2'b01;
  localparam logic [1:0] MODE_ARI = 2'b10;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;
endpackage

// File: rtl/shift_reg_ctrl_if.sv
// Control/data bundle between a requester and the shift register controller.
interface shift_reg_ctrl_if #(parameter int WIDTH = 8);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             load;
  logic [WIDTH-1:0] din;
  logic             start;
  logic             dir;
  logic [1:0]       mode;
  logic [CNT_W-1:0] amount;
  logic             ser_in;
  logic [WIDTH-1:0] dout;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output load, din, start, dir, mode, amount, ser_in,
    input  dout, ser_out, busy, done
  );

  modport slave (
    input  load, din, start, dir, mode, amount, ser_in,
    output dout, ser_out, busy, done
  );
endinterface

// File: rtl/shift_cell.sv
// One register bit: neighbour select, load select, then an enabled flop.
import shift_pkg::*;

module shift_cell (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic ld_i,
  input  logic dir_i,
  input  logic d_i,
  input  logic left_i,
  input  logic right_i,
  output logic q_o
);
  logic nb, d;

  // Shifting right pulls from the higher neighbour, left from the lower one.
  assign nb = (dir_i == DIR_R) ? right_i : left_i;
  assign d  = ld_i ? d_i : nb;

  always_ff @(posedge clk) begin
    if (rst)       q_o <= 1'b0;
    else if (en_i) q_o <= d;
  end
endmodule

// File: rtl/shift_reg_ctrl.sv
// N-bit shift register with load, and a counted logical/rotate/arithmetic shift sequence.
import shift_pkg::*;

module shift_reg_ctrl #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  shift_reg_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             ser_out_q, busy_q, done_q;

  logic [WIDTH-1:0] q, left_nb, right_nb;
  logic             fill, ld, sh;

  assign ld = (state_q == IDLE) && bus.load;
  assign sh = (state_q == SHIFT);

  // Mode 11 falls through to the serial input like logical mode.
  always_comb begin
    fill = bus.ser_in;
    if (mode_q == MODE_ROT)      fill = (dir_q == DIR_R) ? q[0] : q[WIDTH-1];
    else if (mode_q == MODE_ARI) fill = (dir_q == DIR_R) ? q[WIDTH-1] : 1'b0;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lo
      assign left_nb[i] = fill;
    end else begin : g_lo
      assign left_nb[i] = q[i-1];
    end
    if (i == WIDTH-1) begin : g_hi
      assign right_nb[i] = fill;
    end else begin : g_hi
      assign right_nb[i] = q[i+1];
    end

    shift_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .en_i    (ld | sh),
      .ld_i    (ld),
      .dir_i   (dir_q),
      .d_i     (bus.din[i]),
      .left_i  (left_nb[i]),
      .right_i (right_nb[i]),
      .q_o     (q[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        dir_d   = bus.dir;
        mode_d  = bus.mode;
        cnt_d   = bus.amount;
        state_d = (bus.amount == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      mode_q    <= 2'b00;
      ser_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      if (sh) ser_out_q <= (dir_q == DIR_R) ? q[0] : q[WIDTH-1];
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.dout    = q;
  assign bus.ser_out = ser_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Randomized scoreboard bench for shift_reg_ctrl with a closed-form reference model.
module tb_shift_reg_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] dout;
    logic         ser;
    int           amt;
    int           start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  logic [W-1:0] m_dout = '0;
  logic         m_ser  = 1'b0;

  shift_reg_ctrl_if #(.WIDTH(W)) bus ();

  shift_reg_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result of an amt-shift sequence derived from the shift definitions directly.
  task automatic model(input logic [W-1:0] v, input logic sin, input logic dr,
                       input logic [1:0] md, input int amt, input logic [15:0] sb,
                       output logic [W-1:0] vo, output logic so);
    logic [2*W-1:0] t;
    logic signed [W-1:0] sv;
    int r;
    vo = v;
    so = sin;
    if (amt == 0) return;
    if (md == 2'b01) begin
      r = amt % W;
      if (dr == 1'b0) begin t = {v, v} << r; vo = t[2*W-1:W]; so = vo[0]; end
      else            begin t = {v, v} >> r; vo = t[W-1:0];   so = vo[W-1]; end
    end else if (md == 2'b10) begin
      if (dr == 1'b0) begin
        vo = (amt >= W) ? '0 : v << amt;
        so = (amt > W) ? 1'b0 : v[W-amt];
      end else begin
        sv = v;
        vo = sv >>> amt;
        so = (amt > W) ? v[W-1] : v[amt-1];
      end
    end else begin
      for (int j = 0; j < amt; j++) begin
        if (dr == 1'b0) begin so = vo[W-1]; vo = W'((vo << 1) | W'(sb[j])); end
        else            begin so = vo[0];   vo = (vo >> 1) | (W'(sb[j]) << (W-1)); end
      end
    end
  endtask

  // Entered and left just after a negedge with the DUT idle.
  task automatic run_seq(input bit do_load, input logic [W-1:0] d, input logic dr,
                         input logic [1:0] md, input logic [3:0] amt,
                         input logic [15:0] sb, input bit noise);
    exp_t e;
    logic [W-1:0] vo;
    logic so;
    bus.load = do_load; bus.din = d; bus.start = 1'b1;
    bus.dir = dr; bus.mode = md; bus.amount = amt; bus.ser_in = 1'($urandom);
    if (do_load) m_dout = d;
    model(m_dout, m_ser, dr, md, int'(amt), sb, vo, so);
    m_dout = vo; m_ser = so;
    e.dout = vo; e.ser = so; e.amt = int'(amt); e.start_cyc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    bus.load = 1'b0; bus.start = 1'b0;
    for (int j = 0; j < int'(amt); j++) begin
      bus.ser_in = sb[j];
      if (noise) begin
        bus.load = 1'($urandom); bus.din = W'($urandom); bus.start = 1'($urandom);
        bus.dir = 1'($urandom); bus.mode = 2'($urandom); bus.amount = 4'($urandom);
      end
      @(negedge clk);
    end
    if (noise) begin
      bus.load = 1'b1; bus.din = W'($urandom); bus.start = 1'b1; bus.amount = 4'($urandom);
    end
    @(negedge clk);
    bus.load = 1'b0; bus.start = 1'b0; bus.ser_in = 1'($urandom);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  // Monitor: busy run length and completion results, checked on each done pulse.
  initial begin
    int  bcnt = 0;
    bit  pb = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.busy) begin
        bcnt = pb ? bcnt + 1 : 1;
      end else if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("dout", {24'd0, bus.dout}, {24'd0, e.dout});
          chk("ser_out", {31'd0, bus.ser_out}, {31'd0, e.ser});
          chk("busy_cycles", bcnt, e.amt);
          chk("done_latency", cyc - e.start_cyc, e.amt + 1);
        end
        bcnt = 0;
      end else begin
        bcnt = 0;
      end
      pb = bus.busy;
    end
  end

  initial begin
    wait (cyc > 20000);
    $display("FAIL watchdog: got cycle %0d, expected < 20000", cyc);
    $fatal(1);
  end

  initial begin
    bus.load = 1'b0; bus.din = '0; bus.start = 1'b0; bus.dir = 1'b0;
    bus.mode = 2'b00; bus.amount = '0; bus.ser_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", {24'd0, bus.dout}, 32'd0);
    chk("rst_flags", {29'd0, bus.ser_out, bus.busy, bus.done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Abort mid-shift: reset in the second SHIFT cycle.
    bus.load = 1'b1; bus.din = 8'hFF; bus.start = 1'b1; bus.amount = 4'd5;
    @(negedge clk);
    bus.load = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_dout", {24'd0, bus.dout}, 32'd0);
    chk("abort_flags", {30'd0, bus.busy, bus.done}, 32'd0);
    rst = 1'b0;
    m_dout = '0; m_ser = 1'b0;
    repeat (8) @(negedge clk);

    run_seq(1, 8'hB4, 1'b0, 2'b00, 4'd3,  16'hFFFF, 0);
    run_seq(1, 8'h81, 1'b1, 2'b01, 4'd1,  16'h0000, 0);
    run_seq(1, 8'h81, 1'b1, 2'b01, 4'd8,  16'h0000, 0);
    run_seq(1, 8'h90, 1'b1, 2'b10, 4'd2,  16'h0000, 0);
    run_seq(1, 8'h90, 1'b1, 2'b10, 4'd15, 16'h0000, 0);
    run_seq(1, 8'h3C, 1'b0, 2'b00, 4'd0,  16'h0000, 0);
    run_seq(1, 8'h5A, 1'b0, 2'b01, 4'd6,  16'h1234, 1);
    run_seq(1, 8'hC3, 1'b0, 2'b10, 4'd9,  16'h0000, 0);
    run_seq(1, 8'h6E, 1'b1, 2'b11, 4'd12, 16'h0A5F, 0);

    for (int n = 0; n < 60; n++) begin
      run_seq(($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom), 2'($urandom),
              4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
